// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the async FIFO write-side front end.
package async_fifo_pkg;

    localparam int unsigned DataWidthDefault = 8;
    localparam int unsigned SyncStagesMin    = 2;
    localparam int unsigned SyncStagesMax    = 3;
    localparam int unsigned GrayMaxWidth     = 32;

    function automatic logic [GrayMaxWidth-1:0] gray2bin(input logic [GrayMaxWidth-1:0] gray);
        logic [GrayMaxWidth-1:0] bin;
        bin[GrayMaxWidth-1] = gray[GrayMaxWidth-1];
        for (int i = GrayMaxWidth - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_sync.sv
// Multi-flop synchronizer; stages are chained flop-to-flop with nothing in between.
module async_fifo_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_write_frontend.sv
// Write-side front end: read-pointer sync, one-entry skid, optional occupancy.
// Occupancy outputs are generated only when ASYNC_FIFO_WR_OCCUPANCY_EN is defined.
module async_fifo_write_frontend
    import async_fifo_pkg::*;
#(
    parameter int unsigned WRITE_COUNTER_BITS = 4,
    parameter int unsigned DATA_WIDTH         = DataWidthDefault,
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned ALMOST_FULL_THRESH = 6
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          s_valid,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          s_ready,
    output logic                          fifo_push,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    input  logic                          fifo_full,
    input  logic [WRITE_COUNTER_BITS-1:0] write_gcode_ptr,
    input  logic [WRITE_COUNTER_BITS-1:0] read_gcode_ptr,
    output logic [WRITE_COUNTER_BITS-1:0] read_gcode_ptr_wr_sync,
    output logic [WRITE_COUNTER_BITS-1:0] fill_level,
    output logic                          almost_full
);

    localparam int unsigned PtrW = WRITE_COUNTER_BITS;
    // Out-of-range stage counts are clamped into the legal window.
    localparam int unsigned SyncDepth =
        (SYNC_STAGES < SyncStagesMin) ? SyncStagesMin :
        (SYNC_STAGES > SyncStagesMax) ? SyncStagesMax : SYNC_STAGES;

    async_fifo_sync #(
        .WIDTH  (PtrW),
        .STAGES (SyncDepth)
    ) u_rd_ptr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (read_gcode_ptr),
        .q_o     (read_gcode_ptr_wr_sync)
    );

    logic                  rst_done_q, rst_done_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  xfer;

    assign s_ready    = !skid_valid_q && rst_done_q;
    assign xfer       = s_valid && s_ready;
    assign fifo_push  = (skid_valid_q || xfer) && !fifo_full;
    assign fifo_wdata = skid_valid_q ? skid_data_q : s_data;

    always_comb begin
        rst_done_d   = 1'b1;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (xfer && fifo_full) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data;
        end else if (skid_valid_q && !fifo_full) begin
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_done_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            rst_done_q   <= rst_done_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

`ifdef ASYNC_FIFO_WR_OCCUPANCY_EN
    logic [PtrW-1:0] wr_bin, rd_bin, occ_diff;
    logic [PtrW-1:0] fill_q, fill_d;
    logic            almost_full_q, almost_full_d;

    assign wr_bin   = PtrW'(gray2bin(GrayMaxWidth'(write_gcode_ptr)));
    assign rd_bin   = PtrW'(gray2bin(GrayMaxWidth'(read_gcode_ptr_wr_sync)));
    // Modulo-2^N subtraction handles pointer roll-over.
    assign occ_diff = wr_bin - rd_bin;

    always_comb begin
        fill_d        = occ_diff;
        almost_full_d = (32'(occ_diff) >= ALMOST_FULL_THRESH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q        <= '0;
            almost_full_q <= 1'b0;
        end else begin
            fill_q        <= fill_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign fill_level  = fill_q;
    assign almost_full = almost_full_q;
`else
    logic unused_occ;
    assign unused_occ  = ^write_gcode_ptr;
    assign fill_level  = '0;
    assign almost_full = 1'b0;
`endif

endmodule

// File: doc/async_fifo_write_frontend.md
ASYNC_FIFO_WRITE_FRONTEND -- requirements
Module: async_fifo_write_frontend

Interface
REQ-001 Parameters SHALL be one per line as name, default, meaning:
 WRITE_COUNTER_BITS, 4, pointer width N; FIFO depth is 2^(N-1).
 DATA_WIDTH, 8, payload width.
 SYNC_STAGES, 2, synchronizer depth; legal values are 2 and 3.
 ALMOST_FULL_THRESH, 6, fill level at or above which almost_full is asserted.
REQ-002 Ports SHALL be one per line as name, direction, width, meaning:
 clk  in  1  write-domain clock; this is the only clock.
 reset_n  in  1  reset, asynchronous, active-low.
 s_valid  in  1  upstream data valid.
 s_data  in  DATA_WIDTH  upstream payload.
 s_ready  out  1  upstream may transfer.
 fifo_push  out  1  push strobe to the write-control stage.
 fifo_wdata  out  DATA_WIDTH  payload written at the current write address.
 fifo_full  in  1  full flag from the write-control stage.
 write_gcode_ptr  in  N  write Gray pointer from the write-control stage.
 read_gcode_ptr  in  N  read Gray pointer, launched in the read clock domain (asynchronous to clk).
 read_gcode_ptr_wr_sync  out  N  synchronized read pointer, fed to the write-control stage.
 fill_level  out  N  registered write-side occupancy.
 almost_full  out  1  registered flag, asserted when fill_level >= ALMOST_FULL_THRESH.

Function
REQ-003 read_gcode_ptr SHALL pass through SYNC_STAGES flops on clk; the last stage drives read_gcode_ptr_wr_sync.
REQ-004 A one-entry skid register (skid_valid, skid_data) SHALL decouple the upstream handshake from fifo_full.
REQ-005 s_ready SHALL equal !skid_valid && rst_done, where rst_done is a flop set one cycle after reset release.
REQ-006 A transfer SHALL occur when s_valid && s_ready.
REQ-007 fifo_push SHALL equal (skid_valid || (s_valid && s_ready)) && !fifo_full; it is combinational, with zero-cycle latency.
REQ-008 fifo_wdata SHALL be skid_data when skid_valid is set, otherwise s_data.
REQ-009 On a transfer with fifo_full high, s_data SHALL be captured into skid and skid_valid set on the next edge.
REQ-010 On a transfer with fifo_full low and skid empty, data SHALL be pushed directly and the skid left untouched.
REQ-011 When skid_valid is set and fifo_full is low, the skid SHALL be pushed and skid_valid cleared on the next edge.
REQ-012 The block SHALL never drop, duplicate or reorder a transfer; sustained throughput SHALL be 1 per cycle while not full.
REQ-013 The block SHALL never assert fifo_push while fifo_full is high.
REQ-014 Occupancy: wr_bin and rd_bin SHALL be Gray-to-binary conversions of write_gcode_ptr and read_gcode_ptr_wr_sync.
REQ-015 fill_level SHALL be registered as (wr_bin - rd_bin) mod 2^N, one cycle after the pointer change.
REQ-016 fill_level SHALL wrap correctly across pointer roll-over; its maximum value is 2^(N-1).
REQ-017 almost_full SHALL be registered in the same cycle as fill_level, computed from the same difference.

Reset
REQ-018 Asserting reset_n low SHALL immediately clear all synchronizer flops, skid_valid, skid_data, rst_done, fill_level and almost_full.
REQ-019 While reset_n is low, s_ready SHALL be 0 and fifo_push SHALL be 0.
REQ-020 A reset asserted mid-operation SHALL discard any skid contents without a push.

Configuration
REQ-021 With ASYNC_FIFO_WR_OCCUPANCY_EN defined, fill_level and almost_full SHALL be generated as specified in REQ-014 to REQ-017.
REQ-022 Without ASYNC_FIFO_WR_OCCUPANCY_EN, fill_level and almost_full SHALL be tied to 0 and the occupancy logic omitted; the ports remain present.

Structure
REQ-023 Package async_fifo_pkg SHALL hold the gray2bin function, the SYNC_STAGES legal-range constants and the DATA_WIDTH default.
REQ-024 The synchronizer SHALL be a sub-module, async_fifo_sync, parameterized by width and stage count, with no logic between stages.

Verification (N=4, depth 8, SYNC_STAGES=2)
REQ-025 Release reset with s_valid=1 -> s_ready=0 in the release cycle, s_ready=1 the next cycle, and no push before that.
REQ-026 Stream 8 words with the read pointer static at 0 -> 8 pushes on consecutive cycles, fifo_full rises, the 9th word is held in skid, and s_ready=0.
REQ-027 From the state of REQ-026, advance the read Gray pointer by 1 -> fifo_full drops 2 cycles later, the skid word is pushed that cycle, and s_ready=1 on the next cycle.
REQ-028 Write pointer 14 (binary) and read pointer 11 converted to Gray, at wrap -> fill_level=3; with ALMOST_FULL_THRESH=6 at level 6 -> almost_full=1 one cycle later.
REQ-029 Assert reset_n low while skid_valid=1 -> skid is discarded and no fifo_push occurs; the word count checked by the scoreboard excludes the dropped word.
REQ-030 Build without ASYNC_FIFO_WR_OCCUPANCY_EN and repeat REQ-028 -> fill_level=0 and almost_full=0 throughout.
